aes128_iter_core: RTL and testbench



---
 rtl/aes128_iter_core_pkg.sv | 55 +++++
 rtl/aes128_iter_core_if.sv | 13 +
 rtl/aes128_iter_core_sbox.sv | 11 +
 rtl/aes128_iter_core.sv | 119 +++++++++++
 tb/tb_aes128_iter_core.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_iter_core_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the iterative cipher core:
// S-box and Rcon tables, xtime, and the MixColumns single-column transform.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS = 10;
   localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } ctrl_e;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Indexed directly by the round counter; entries outside rounds 1..10 are unused.
   localparam logic [0:15][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes are packed row 0 in the MSB, matching the state byte order.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes128_iter_core_if.sv
// Load/result bundle between a host (master) and the AES-128 core (slave).
interface aes128_iter_core_if;

   logic         ld;
   logic [127:0] key;
   logic [127:0] text_in;
   logic         done;
   logic [127:0] text_out;

   modport master (output ld, key, text_in, input done, text_out);
   modport slave  (input ld, key, text_in, output done, text_out);

endinterface

// File: rtl/aes128_iter_core_sbox.sv
// Combinational AES S-box lookup for one byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   assign y_o = SBOX[a_i];

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one full round per clock, round keys expanded
// on the fly alongside the state so only the current round key is stored.
module aes128_iter_core
   import aes_pkg::*;
(
   input logic               clk,
   input logic               rst,
   aes128_iter_core_if.slave bus
);

   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [3:0]   cnt_q, cnt_d;
   ctrl_e        ctrl_q, ctrl_d;
   logic         done_q, done_d;
   logic [127:0] text_out_q, text_out_d;

   logic [7:0]   sb [16];
   logic [127:0] sr_flat;
   logic [127:0] mc_flat;
   logic [127:0] round_out;
   logic         last_round;

   logic [31:0]  w3_rot;
   logic [7:0]   kb [4];
   logic [31:0]  key_temp;
   logic [127:0] next_key;

   // State bytes are column-major: byte i sits at row i%4, column i/4.
   for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
      aes_sbox u_sbox (.a_i(state_q[127-8*i -: 8]), .y_o(sb[i]));
   end

   always_comb begin
      sr_flat = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_flat[127-8*(r+4*c) -: 8] = sb[r + 4*((c + r) % 4)];
         end
      end
   end

   always_comb begin
      mc_flat = '0;
      for (int c = 0; c < 4; c++) begin
         mc_flat[127-32*c -: 32] = mix_column(sr_flat[127-32*c -: 32]);
      end
   end

   assign w3_rot = {rkey_q[23:0], rkey_q[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_sub_word
      aes_sbox u_sbox (.a_i(w3_rot[31-8*j -: 8]), .y_o(kb[j]));
   end

   assign key_temp = {kb[0], kb[1], kb[2], kb[3]} ^ {RCON[cnt_q], 24'h000000};

   // Each new word chains off the one just produced, so the XORs ripple left to right.
   assign next_key[127:96] = rkey_q[127:96] ^ key_temp;
   assign next_key[95:64]  = rkey_q[95:64]  ^ next_key[127:96];
   assign next_key[63:32]  = rkey_q[63:32]  ^ next_key[95:64];
   assign next_key[31:0]   = rkey_q[31:0]   ^ next_key[63:32];

   assign last_round = (cnt_q == LAST_ROUND);
   assign round_out  = (last_round ? sr_flat : mc_flat) ^ next_key;

   // NOTE: every next-state signal gets its hold value first, so no path
   // through this block can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      rkey_d     = rkey_q;
      cnt_d      = cnt_q;
      ctrl_d     = ctrl_q;
      done_d     = done_q;
      text_out_d = text_out_q;

      if (bus.ld) begin
         state_d = bus.text_in ^ bus.key;
         rkey_d  = bus.key;
         cnt_d   = 4'd1;
         ctrl_d  = ST_BUSY;
         done_d  = 1'b0;
      end else if (ctrl_q == ST_BUSY) begin
         state_d = round_out;
         rkey_d  = next_key;
         cnt_d   = cnt_q + 4'd1;
         if (last_round) begin
            ctrl_d     = ST_IDLE;
            done_d     = 1'b1;
            text_out_d = round_out;
            cnt_d      = 4'd0;
         end
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= '0;
         rkey_q     <= '0;
         cnt_q      <= '0;
         ctrl_q     <= ST_IDLE;
         done_q     <= 1'b0;
         text_out_q <= '0;
      end else begin
         state_q    <= state_d;
         rkey_q     <= rkey_d;
         cnt_q      <= cnt_d;
         ctrl_q     <= ctrl_d;
         done_q     <= done_d;
         text_out_q <= text_out_d;
      end
   end

   assign bus.done     = done_q;
   assign bus.text_out = text_out_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Self-checking bench for aes128_iter_core: FIPS-197 vectors, restart and reset
// corner cases, and random vectors against a from-first-principles AES model.
module tb_aes128_iter_core;

   logic clk;
   logic rst;

   aes128_iter_core_if bus ();

   aes128_iter_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks;
   int errors;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t vecs [3];

   logic [7:0] sbox_ref [256];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // S-box derived from the multiplicative inverse plus the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
         end
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [7:0]   rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h000000};
            rc  = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_ref[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*c] = t[r + 4*((c + r) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = s[r+4*c];
               for (int r = 0; r < 4; r++)
                  s[r+4*c] = gf_mul(8'h02, a[r]) ^ gf_mul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a falling edge; the load is sampled on the next rising edge.
   task automatic do_ld(input logic [127:0] k, input logic [127:0] p);
      bus.ld      = 1'b1;
      bus.key     = k;
      bus.text_in = p;
      @(negedge clk);
      bus.ld      = 1'b0;
      bus.key     = rand128();
      bus.text_in = rand128();
   endtask

   // Counts falling edges until done rises; -1 if the budget runs out.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int           lat;
      logic         ok;
      logic [127:0] k;
      logic [127:0] p;
      logic [127:0] held;

      checks = 0;
      errors = 0;
      clk         = 1'b0;
      rst         = 1'b0;
      bus.ld      = 1'b0;
      bus.key     = '0;
      bus.text_in = '0;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32};
      vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

      build_sbox();

      #1;
      check("reset_done", 128'(bus.done), 128'd0);
      check("reset_text_out", bus.text_out, 128'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      ok = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (bus.done !== 1'b0) ok = 1'b0;
      end
      check("no_done_without_ld", 128'(ok), 128'd1);

      for (int v = 0; v < 3; v++) begin
         do_ld(vecs[v].key, vecs[v].pt);
         check($sformatf("vec%0d_done_low_after_ld", v), 128'(bus.done), 128'd0);
         wait_done(lat);
         check($sformatf("vec%0d_latency", v), 128'(lat), 128'd10);
         check($sformatf("vec%0d_text_out", v), bus.text_out, vecs[v].ct);
      end

      // Zero vector result must stay put with no further loads.
      ok = 1'b1;
      held = bus.text_out;
      repeat (55) begin
         @(negedge clk);
         if (bus.done !== 1'b1 || bus.text_out !== held) ok = 1'b0;
      end
      check("hold_stable", 128'(ok), 128'd1);
      check("hold_text_out", bus.text_out, vecs[2].ct);

      // Restart: second load 4 cycles after the first, only its result appears.
      do_ld(vecs[1].key, vecs[1].pt);
      ok = (bus.done === 1'b0);
      repeat (3) begin
         @(negedge clk);
         if (bus.done !== 1'b0) ok = 1'b0;
      end
      do_ld(vecs[0].key, vecs[0].pt);
      if (bus.done !== 1'b0) ok = 1'b0;
      check("restart_no_early_done", 128'(ok), 128'd1);
      wait_done(lat);
      check("restart_latency", 128'(lat), 128'd10);
      check("restart_text_out", bus.text_out, vecs[0].ct);

      // Load held high for three edges: counting starts from the last one.
      k = rand128();
      p = rand128();
      bus.ld      = 1'b1;
      bus.key     = k;
      bus.text_in = p;
      repeat (3) @(negedge clk);
      bus.ld = 1'b0;
      wait_done(lat);
      check("held_ld_latency", 128'(lat), 128'd10);
      check("held_ld_text_out", bus.text_out, aes_ref(k, p));

      // Asynchronous reset away from any clock edge clears outputs at once.
      #2 rst = 1'b0;
      #1;
      check("async_reset_done", 128'(bus.done), 128'd0);
      check("async_reset_text_out", bus.text_out, 128'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset mid-operation: the aborted job must never complete.
      do_ld(rand128(), rand128());
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.text_out !== 128'd0) ok = 1'b0;
      end
      check("midrun_reset_quiet", 128'(ok), 128'd1);

      for (int n = 0; n < 30; n++) begin
         k = rand128();
         p = rand128();
         do_ld(k, p);
         wait_done(lat);
         check($sformatf("rand%0d_latency", n), 128'(lat), 128'd10);
         repeat (40) @(negedge clk);
         check($sformatf("rand%0d_done", n), 128'(bus.done), 128'd1);
         check($sformatf("rand%0d_text_out", n), bus.text_out, aes_ref(k, p));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
